// File: rtl/jaluseq_if.sv
// Operand/result handshake bundle between a bus-side caller and the jaluseq ALU sequencer.
// Handshake: a start is accepted on a rising edge where wstart=1 and wready=1; wready stays low
// until the op retires, and wdone pulses for one cycle when bacc/bflags carry the new result.
interface jaluseq_if;
  logic [0:7] bbus;
  logic       wstart;
  logic [0:2] bop;
  logic       wci;
  logic       wbit1;
  logic       wready;
  logic       wbusy;
  logic       wdone;
  logic [0:7] bacc;
  logic [0:3] bflags;
  logic [1:0] fsm_state;

  modport master (
    output bbus, wstart, bop, wci, wbit1,
    input  wready, wbusy, wdone, bacc, bflags, fsm_state
  );

  modport slave (
    input  bbus, wstart, bop, wci, wbit1,
    output wready, wbusy, wdone, bacc, bflags, fsm_state
  );
endinterface

// File: rtl/jaluseq.sv
// ALU operand/result sequencer: B (TMP) then A from the shared bus, then one registered ALU op
// into ACC and {C, A, E, Z}. Bit 0 is the MSB on every vector.
module jaluseq (
  input  logic     wclk,
  input  logic     wrst,
  jaluseq_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, OPA = 2'd1, EXEC = 2'd2} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [0:7] tmp;
  logic [0:7] opnd_a;
  logic [0:2] op;
  logic       ci;
  logic [0:7] acc;
  logic [0:3] flags;
  logic       done;
  logic       ready;

  logic [0:8] sum;
  logic [0:7] res;
  logic       c_out;
  logic       a_gt;
  logic       a_eq;

  always_ff @(posedge wclk) begin
    if (wrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.wstart) state_nxt = OPA;
      OPA:     state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  // Combinational ALU slices; only EXEC consumes these.
  always_comb begin
    sum   = {1'b0, opnd_a} + {1'b0, tmp} + {8'd0, ci};
    res   = '0;
    c_out = 1'b0;
    case (op)
      3'b000: begin res = sum[1:8];            c_out = sum[0];    end
      3'b001: begin res = {ci, opnd_a[0:6]};   c_out = opnd_a[7]; end
      3'b010: begin res = {opnd_a[1:7], ci};   c_out = opnd_a[0]; end
      3'b011: res = ~opnd_a;
      3'b100: res = opnd_a & tmp;
      3'b101: res = opnd_a | tmp;
      default: res = opnd_a ^ tmp;
    endcase
    a_gt = (opnd_a > tmp);
    a_eq = (opnd_a == tmp);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      tmp    <= '0;
      opnd_a <= '0;
      op     <= '0;
      ci     <= 1'b0;
      acc    <= '0;
      flags  <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == EXEC);
      case (state)
        IDLE: if (bus.wstart) begin
          tmp <= bus.wbit1 ? 8'h01 : bus.bbus;
          op  <= bus.bop;
          ci  <= bus.wci;
        end
        OPA: opnd_a <= bus.bbus;
        EXEC: begin
          // CMP updates flags only; ACC keeps the previous result.
          if (op != 3'b111) acc <= res;
          flags <= {c_out, a_gt, a_eq, (res == 8'h00)};
        end
        default: ;
      endcase
    end
  end

  assign bus.wready    = ready;
  assign bus.wbusy     = ~ready;
  assign bus.wdone     = done;
  assign bus.bacc      = acc;
  assign bus.bflags    = flags;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_jaluseq.sv
// Directed bench for jaluseq: a transaction-level result model with per-cycle comparison,
// plus literal expectations taken from hand-worked examples.
module tb_jaluseq;
  logic wclk = 1'b0;
  logic wrst = 1'b1;

  jaluseq_if bus ();

  jaluseq dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge wclk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] acc;
    logic [3:0] flags;
    bit         wr;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_acc   = 8'h00;
  logic [3:0] exp_flags = 4'h0;
  logic       exp_done;
  logic       exp_ready;
  int         reset_due = -1;
  bit         checking  = 1'b0;

  // Result of one operation from the arithmetic definition of each opcode.
  function automatic exp_t model(input int op, input int a, input int b, input int ci);
    exp_t m;
    int   r;
    int   c;
    c = 0;
    case (op)
      0: begin r = a + b + ci; c = r >> 8; r = r & 255; end
      1: begin r = (ci << 7) | (a >> 1); c = a & 1; end
      2: begin r = ((a << 1) & 255) | ci; c = (a >> 7) & 1; end
      3: r = (~a) & 255;
      4: r = a & b;
      5: r = a | b;
      default: r = a ^ b;
    endcase
    m.due   = 0;
    m.acc   = 8'(r);
    m.flags = {1'(c), 1'(a > b), 1'(a == b), 1'(r == 0)};
    m.wr    = (op != 7);
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge wclk) begin
    if (checking) begin
      exp_done = 1'b0;
      if (cyc == reset_due) begin
        exp_q.delete();
        exp_acc   = 8'h00;
        exp_flags = 4'h0;
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        if (exp_q[0].wr) exp_acc = exp_q[0].acc;
        exp_flags = exp_q[0].flags;
        exp_done  = 1'b1;
        void'(exp_q.pop_front());
      end
      exp_ready = !(exp_q.size() > 0 && cyc >= exp_q[0].due - 2);
      chk("acc",   32'(bus.bacc),   32'(exp_acc));
      chk("flags", 32'(bus.bflags), 32'(exp_flags));
      chk("done",  32'(bus.wdone),  32'(exp_done));
      chk("ready", 32'(bus.wready), 32'(exp_ready));
      chk("busy",  32'(bus.wbusy),  32'(!exp_ready));
    end
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.wstart = 1'b0;
    repeat (n) step();
  endtask

  // Drives one op over three cycles; junk holds wstart high during OPA/EXEC.
  task automatic do_op(input int op, input int b, input int a, input int ci,
                       input bit bit1, input bit junk);
    exp_t e;
    bus.wstart = 1'b1;
    bus.bop    = 3'(op);
    bus.wci    = 1'(ci);
    bus.wbit1  = bit1;
    bus.bbus   = bit1 ? 8'hAA : 8'(b);
    e     = model(op, a, bit1 ? 1 : b, ci);
    e.due = cyc + 3;
    exp_q.push_back(e);
    step();
    bus.wstart = junk;
    bus.bbus   = 8'(a);
    bus.bop    = 3'($urandom_range(0, 7));
    bus.wci    = 1'($urandom_range(0, 1));
    bus.wbit1  = 1'($urandom_range(0, 1));
    step();
    bus.wstart = junk;
    bus.bbus   = 8'($urandom_range(0, 255));
    step();
    bus.wstart = 1'b0;
  endtask

  initial begin
    bus.bbus   = 8'h00;
    bus.wstart = 1'b0;
    bus.bop    = 3'd0;
    bus.wci    = 1'b0;
    bus.wbit1  = 1'b0;
    wrst       = 1'b1;
    repeat (3) step();
    wrst     = 1'b0;
    checking = 1'b1;
    chk("rst_acc",   32'(bus.bacc),   32'h00);
    chk("rst_flags", 32'(bus.bflags), 32'h0);
    chk("rst_ready", 32'(bus.wready), 32'h1);
    chk("rst_busy",  32'(bus.wbusy),  32'h0);
    chk("rst_done",  32'(bus.wdone),  32'h0);
    idle(2);

    do_op(0, 8'h05, 8'h03, 0, 1'b0, 1'b0);
    chk("add_acc",   32'(bus.bacc),   32'h08);
    chk("add_flags", 32'(bus.bflags), 32'h0);
    chk("add_done",  32'(bus.wdone),  32'h1);
    idle(1);

    do_op(0, 8'h01, 8'hFF, 0, 1'b0, 1'b0);
    chk("ovf_acc",   32'(bus.bacc),   32'h00);
    chk("ovf_flags", 32'(bus.bflags), 32'hD);
    idle(1);

    do_op(0, 8'h55, 8'h7F, 0, 1'b1, 1'b0);
    chk("bit1_acc",   32'(bus.bacc),   32'h80);
    chk("bit1_flags", 32'(bus.bflags), 32'h4);
    idle(1);

    do_op(1, 8'h00, 8'h02, 1, 1'b0, 1'b0);
    chk("shr_acc", 32'(bus.bacc),      32'h81);
    chk("shr_c",   32'(bus.bflags[0]), 32'h0);
    idle(1);

    do_op(2, 8'h00, 8'h81, 0, 1'b0, 1'b0);
    chk("shl_acc", 32'(bus.bacc),      32'h02);
    chk("shl_c",   32'(bus.bflags[0]), 32'h1);
    idle(1);

    do_op(5, 8'h33, 8'h00, 0, 1'b0, 1'b0);
    chk("or_acc", 32'(bus.bacc), 32'h33);
    do_op(7, 8'h5A, 8'h5A, 0, 1'b0, 1'b0);
    chk("cmp_acc",   32'(bus.bacc),   32'h33);
    chk("cmp_flags", 32'(bus.bflags), 32'h3);
    idle(1);

    do_op(3, 8'h00, 8'h0F, 1, 1'b0, 1'b0);
    chk("not_acc", 32'(bus.bacc), 32'hF0);
    do_op(4, 8'hF0, 8'h3C, 0, 1'b0, 1'b1);
    chk("and_junk_acc", 32'(bus.bacc), 32'h30);
    idle(4);

    do_op(6, 8'hA5, 8'h0F, 0, 1'b0, 1'b0);
    do_op(0, 8'h10, 8'h20, 1, 1'b0, 1'b0);
    chk("b2b_acc",  32'(bus.bacc),  32'h31);
    chk("b2b_done", 32'(bus.wdone), 32'h1);
    do_op(6, 8'h0F, 8'h0F, 0, 1'b0, 1'b0);
    idle(1);
    do_op(0, 8'h40, 8'h02, 0, 1'b0, 1'b0);
    idle(1);

    // Reset landing on the EXEC edge of an ADD.
    begin
      exp_t e;
      bus.wstart = 1'b1;
      bus.bop    = 3'd0;
      bus.wci    = 1'b0;
      bus.wbit1  = 1'b0;
      bus.bbus   = 8'h10;
      e     = model(0, 8'h22, 8'h10, 0);
      e.due = cyc + 3;
      exp_q.push_back(e);
      step();
      bus.wstart = 1'b0;
      bus.bbus   = 8'h22;
      step();
      wrst      = 1'b1;
      reset_due = cyc + 1;
      step();
      wrst = 1'b0;
      chk("rexec_acc",   32'(bus.bacc),   32'h00);
      chk("rexec_flags", 32'(bus.bflags), 32'h0);
      chk("rexec_done",  32'(bus.wdone),  32'h0);
      chk("rexec_ready", 32'(bus.wready), 32'h1);
    end
    idle(3);

    do_op(0, 8'h11, 8'h22, 0, 1'b0, 1'b0);
    idle(1);
    wrst       = 1'b1;
    bus.wstart = 1'b1;
    bus.bbus   = 8'h77;
    reset_due  = cyc + 1;
    step();
    wrst       = 1'b0;
    bus.wstart = 1'b0;
    chk("rstart_ready", 32'(bus.wready), 32'h1);
    chk("rstart_acc",   32'(bus.bacc),   32'h00);
    idle(3);

    do_op(4, 8'hFF, 8'hC3, 0, 1'b0, 1'b0);
    chk("post_rst_acc", 32'(bus.bacc), 32'hC3);
    idle(2);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jaluseq.md
# jaluseq

ALU operand/result sequencer sitting directly downstream of the bus and bus1 stage, and around the combinational ALU slices (shifters, notter, andder, orer, adder, comparator, zero detect). It captures operand B into TMP and operand A from the shared 8-bit bus on consecutive cycles. It then evaluates one of eight ALU operations and registers the result into ACC and the C/A/E/Z flags. It replaces the ad-hoc stepper timing around the ALU with a ready/start/done handshake.

## Interface

Parameters:
- none; width fixed at 8, bit 0 is MSB (`[0:7]` ordering throughout).

Ports:
- wclk  in  1  system clock; all state updates on rising edge.
- wrst  in  1  reset, synchronous, active-high.
- bbus  in  [0:7]  shared data bus; operand source.
- wstart  in  1  start request; accepted only while wready=1.
- bop  in  [0:2]  opcode, sampled with wstart: 000 ADD, 001 SHR, 010 SHL, 011 NOT, 100 AND, 101 OR, 110 XOR, 111 CMP.
- wci  in  1  carry in, sampled with wstart.
- wbit1  in  1  bus1 select, sampled with wstart: TMP loads 0x01 instead of bbus.
- wready  out  1  high in IDLE.
- wbusy  out  1  inverse of wready.
- wdone  out  1  one-cycle pulse when ACC/flags have been updated.
- bacc  out  [0:7]  accumulator register.
- bflags  out  [0:3]  registered flags {C, A, E, Z}.

## Operation

- States: IDLE, OPA, EXEC. Reset forces IDLE from any state, including mid-operation.
- In IDLE with wstart=1:
  - latch TMP <= (wbit1 ? 0x01 : bbus); 0x01 means bits 0..6 = 0 and bit 7 = 1.
  - latch op <= bop and ci <= wci.
  - go to OPA.
- In IDLE with wstart=0: hold.
- OPA: latch A <= bbus; go to EXEC. wstart is ignored.
- EXEC: compute from the A and TMP (B) registers; at the clock edge write ACC and flags, set wdone; go to IDLE.
- Result rules; B = TMP, all unsigned, C is carry out of bit 0 unless stated:
  - ADD: {C, r} = A + B + ci.
  - SHR: r[0]=ci, r[j]=A[j-1] for j=1..7; C=A[7].
  - SHL: r[j-1]=A[j] for j=1..7, r[7]=ci; C=A[0].
  - NOT: r=~A; C=0.
  - AND: r=A&B; C=0.
  - OR: r=A|B; C=0.
  - XOR: r=A^B; C=0.
  - CMP: r=A^B but ACC is NOT written; C=0.
- A flag = (A > B) and E flag = (A == B); both are computed for every opcode.
- Z = (r == 0); for CMP, r is the XOR value.
- All four flags are written in EXEC for every opcode.
- Between operations, ACC and flags hold their values. TMP and A are internal registers only.
- Reset values:
  - state IDLE, so wready=1 and wbusy=0.
  - wdone=0.
  - bacc=0x00, bflags=0000.
  - TMP, A, op and ci all 0.

## Timing

- Cycle 0 (IDLE, wstart=1): B, op, ci and bit1 sampled at the edge.
- Cycle 1 (OPA): the caller must drive A on bbus; sampled at the edge.
- Cycle 2 (EXEC): result computed; ACC and flags written at the edge.
- Cycle 3: new bacc/bflags are visible, wdone=1, state is IDLE, wready=1.
- Latency from wstart edge to visible result: 3 cycles. Throughput: one operation per 3 cycles.
- Back-to-back: wstart=1 in cycle 3 (while wdone=1) is accepted, and the next op starts.
- wdone is registered and lasts exactly one cycle. It does not assert after a reset that interrupted an operation.
- wready and wbusy are decoded from state; no combinational path from inputs.
- Reset during OPA or EXEC: at that edge ACC and flags go to 0 and the state goes to IDLE. There is no partial write and no wdone.
- Reset asserted together with wstart: reset wins.
- bbus is sampled only in IDLE (when wstart=1) and in OPA. Its value in any other cycle has no effect.

## Test plan

- ADD, B=0x05, A=0x03, ci=0:
  - cycle 3: bacc=0x08, bflags C0 A0 E0 Z0, wdone=1.
  - wready is low for exactly cycles 1–2.
- ADD overflow, B=0x01, A=0xFF, ci=0 -> bacc=0x00, C1 A1 E0 Z1.
- Repeat ADD with wbit1=1, bbus=0xAA in cycle 0, A=0x7F -> bacc=0x80 (TMP=0x01, not 0xAA), C0 A1 E0 Z0.
- SHR with ci=1, A=0x02 -> bacc=0x81, C0.
- SHL with ci=0, A=0x81 -> bacc=0x02, C1.
- CMP with ACC preloaded to 0x33 by a prior op, A=B=0x5A -> bacc stays 0x33, flags C0 A0 E1 Z1.
- Control and reset behaviour:
  - wstart pulsed in OPA and EXEC is ignored.
  - Back-to-back start in the wdone cycle: second result lands 3 cycles later, wdone pulses once per op.
  - wrst asserted in EXEC -> next cycle bacc=0x00, bflags=0000, wdone=0, wready=1.
